mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 30 +++
 rtl/mem_access_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Request/memory bus bundle for mem_access_ctrl.
// The master side is the requester plus memory model; the slave side is the controller.
interface mem_access_ctrl_if;
   logic        req;
   logic [2:0]  op;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic [31:0] mem_rdata;
   logic [31:0] mem_addr;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [1:0]  LoadSize_Ctrl;
   logic        MDR_Load;
   logic [31:0] load_data;
   logic        busy;
   logic        done;
   logic        addr_err;

   modport slave (
      input  req, op, addr, store_data, mem_rdata,
      output mem_addr, mem_wr, mem_wdata, LoadSize_Ctrl, MDR_Load,
             load_data, busy, done, addr_err
   );

   modport master (
      output req, op, addr, store_data, mem_rdata,
      input  mem_addr, mem_wr, mem_wdata, LoadSize_Ctrl, MDR_Load,
             load_data, busy, done, addr_err
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store memory access controller.
// Every access does a read (RD_WAIT + CAPTURE); stores then merge the read word
// with the store source and write it back (WR). All outputs are registered and
// are computed from the next state so they line up with the state they describe.
module mem_access_ctrl #(
   parameter int unsigned MEM_LAT = 1
) (
   input logic              clk,
   input logic              reset,
   mem_access_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_WAIT = 3'd1,
      S_CAPTURE = 3'd2,
      S_WR      = 3'd3,
      S_DONE    = 3'd4,
      S_ERR     = 3'd5
   } state_t;

   localparam logic [2:0] LAT = 3'(MEM_LAT);

   // op[1:0]: 00 word, 01 halfword, 10 byte, 11 invalid; op[2] selects store.
   function automatic logic f_op_valid(input logic [1:0] sz);
      return (sz != 2'b11);
   endfunction

   function automatic logic f_aligned(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         2'b00:   return (a == 2'b00);
         2'b01:   return (a[0] == 1'b0);
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [1:0] f_lsz(input logic [1:0] sz);
      case (sz)
         2'b01:   return 2'b01;
         2'b10:   return 2'b00;
         default: return 2'b10;
      endcase
   endfunction

   function automatic logic [31:0] f_load(input logic [1:0] sz, input logic [31:0] rd);
      case (sz)
         2'b01:   return {16'd0, rd[15:0]};
         2'b10:   return {24'd0, rd[7:0]};
         default: return rd;
      endcase
   endfunction

   function automatic logic [31:0] f_merge(input logic [1:0] sz, input logic [31:0] sd,
                                           input logic [31:0] rd);
      case (sz)
         2'b01:   return {rd[31:16], sd[15:0]};
         2'b10:   return {rd[31:8], sd[7:0]};
         default: return sd;
      endcase
   endfunction

   state_t      r_state, w_state_nx;
   logic [2:0]  r_cnt, w_cnt_nx;
   logic [2:0]  r_op, w_op_nx;
   logic [31:0] r_addr, w_addr_nx;
   logic [31:0] r_sd, w_sd_nx;
   logic [31:0] r_load_data, w_load_data_nx;
   logic [31:0] w_mem_wdata_nx;
   logic [31:0] w_mem_addr_nx;
   logic [1:0]  w_lsz_nx;

   logic [31:0] r_mem_addr;
   logic        r_mem_wr;
   logic [31:0] r_mem_wdata;
   logic [1:0]  r_lsz;
   logic        r_mdr;
   logic        r_busy;
   logic        r_done;
   logic        r_err;

   // Next-state, latched-request and next-output computation.
   always_comb begin
      w_state_nx     = r_state;
      w_cnt_nx       = r_cnt;
      w_op_nx        = r_op;
      w_addr_nx      = r_addr;
      w_sd_nx        = r_sd;
      w_load_data_nx = r_load_data;
      w_mem_wdata_nx = 32'd0;
      case (r_state)
         S_IDLE: begin
            if (bus.req) begin
               if (f_op_valid(bus.op[1:0]) && f_aligned(bus.op[1:0], bus.addr[1:0])) begin
                  w_state_nx = S_RD_WAIT;
                  w_cnt_nx   = LAT;
                  w_op_nx    = bus.op;
                  w_addr_nx  = bus.addr;
                  w_sd_nx    = bus.store_data;
               end else begin
                  w_state_nx = S_ERR;
               end
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         S_RD_WAIT: begin
            if (r_cnt <= 3'd1) begin
               w_state_nx = S_CAPTURE;
               w_cnt_nx   = 3'd0;
            end else begin
               w_cnt_nx   = r_cnt - 3'd1;
            end
         end
         S_CAPTURE: begin
            if (r_op[2]) begin
               w_state_nx     = S_WR;
               w_mem_wdata_nx = f_merge(r_op[1:0], r_sd, bus.mem_rdata);
            end else begin
               w_state_nx     = S_DONE;
               w_load_data_nx = f_load(r_op[1:0], bus.mem_rdata);
            end
         end
         S_WR:    w_state_nx = S_DONE;
         S_DONE:  w_state_nx = S_IDLE;
         S_ERR:   w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase

      if ((w_state_nx == S_RD_WAIT) || (w_state_nx == S_CAPTURE) || (w_state_nx == S_WR)) begin
         w_mem_addr_nx = w_addr_nx;
      end else begin
         w_mem_addr_nx = 32'd0;
      end

      if ((w_state_nx == S_IDLE) || (w_state_nx == S_ERR)) begin
         w_lsz_nx = 2'b10;
      end else begin
         w_lsz_nx = f_lsz(w_op_nx[1:0]);
      end
   end

   // State, request latches and registered outputs; reset aborts any access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= 3'd0;
         r_op        <= 3'd0;
         r_addr      <= 32'd0;
         r_sd        <= 32'd0;
         r_load_data <= 32'd0;
         r_mem_addr  <= 32'd0;
         r_mem_wr    <= 1'b0;
         r_mem_wdata <= 32'd0;
         r_lsz       <= 2'b10;
         r_mdr       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_cnt       <= w_cnt_nx;
         r_op        <= w_op_nx;
         r_addr      <= w_addr_nx;
         r_sd        <= w_sd_nx;
         r_load_data <= w_load_data_nx;
         r_mem_addr  <= w_mem_addr_nx;
         r_mem_wr    <= (w_state_nx == S_WR);
         r_mem_wdata <= w_mem_wdata_nx;
         r_lsz       <= w_lsz_nx;
         r_mdr       <= (w_state_nx == S_CAPTURE) && !w_op_nx[2];
         r_busy      <= (w_state_nx != S_IDLE);
         r_done      <= (w_state_nx == S_DONE) || (w_state_nx == S_ERR);
         r_err       <= (w_state_nx == S_ERR);
      end
   end

   assign bus.mem_addr      = r_mem_addr;
   assign bus.mem_wr        = r_mem_wr;
   assign bus.mem_wdata     = r_mem_wdata;
   assign bus.LoadSize_Ctrl = r_lsz;
   assign bus.MDR_Load      = r_mdr;
   assign bus.load_data     = r_load_data;
   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
   assign bus.addr_err      = r_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: two instances (MEM_LAT=1 and MEM_LAT=3)
// share stimulus; tb_sel picks which one receives req and is watched.
module tb_mem_access_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        tb_sel;
   logic        tb_req;
   logic [2:0]  tb_op;
   logic [31:0] tb_addr;
   logic [31:0] tb_sd;
   logic [31:0] tb_rdata;

   mem_access_ctrl_if if1 ();
   mem_access_ctrl_if if3 ();

   assign if1.req        = tb_req & ~tb_sel;
   assign if3.req        = tb_req & tb_sel;
   assign if1.op         = tb_op;
   assign if3.op         = tb_op;
   assign if1.addr       = tb_addr;
   assign if3.addr       = tb_addr;
   assign if1.store_data = tb_sd;
   assign if3.store_data = tb_sd;
   assign if1.mem_rdata  = tb_rdata;
   assign if3.mem_rdata  = tb_rdata;

   mem_access_ctrl #(.MEM_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
   mem_access_ctrl #(.MEM_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3.slave));

   logic        m_busy, m_done, m_err, m_wr, m_mdr;
   logic [31:0] m_maddr, m_wdata, m_ld;
   logic [1:0]  m_lsz;
   assign m_busy  = tb_sel ? if3.busy          : if1.busy;
   assign m_done  = tb_sel ? if3.done          : if1.done;
   assign m_err   = tb_sel ? if3.addr_err      : if1.addr_err;
   assign m_wr    = tb_sel ? if3.mem_wr        : if1.mem_wr;
   assign m_mdr   = tb_sel ? if3.MDR_Load      : if1.MDR_Load;
   assign m_maddr = tb_sel ? if3.mem_addr      : if1.mem_addr;
   assign m_wdata = tb_sel ? if3.mem_wdata     : if1.mem_wdata;
   assign m_ld    = tb_sel ? if3.load_data     : if1.load_data;
   assign m_lsz   = tb_sel ? if3.LoadSize_Ctrl : if1.LoadSize_Ctrl;

   typedef struct {
      logic        err;
      int          lat;
      int          mdr;
      int          wr;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [31:0] ld;
      logic [1:0]  lsz;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk    = 0;
   int   n_bad    = 0;
   int   done_cnt = 0;
   int   nd       = 0;

   function automatic exp_t mk(input logic err, input int lat, input int mdr, input int wr,
                               input logic [31:0] waddr, input logic [31:0] wdata,
                               input logic [31:0] ld, input logic [1:0] lsz);
      exp_t e;
      e.err = err; e.lat = lat; e.mdr = mdr; e.wr = wr;
      e.waddr = waddr; e.wdata = wdata; e.ld = ld; e.lsz = lsz;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: tracks cycle number within each busy period and checks on done/mem_wr.
   initial begin : monitor
      int   cyc, mdr_at, wr_at, mdr_n, wr_n;
      logic lsz_bad, prev_busy, after_done;
      exp_t e;
      cyc = 0; mdr_at = 0; wr_at = 0; mdr_n = 0; wr_n = 0;
      lsz_bad = 1'b0; prev_busy = 1'b0; after_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_busy  = 1'b0;
            after_done = 1'b0;
            cyc        = 0;
         end else begin
            if (after_done) begin
               chk("busy_after_done", m_busy, 0);
               after_done = 1'b0;
            end
            if (m_busy && !prev_busy) begin
               cyc = 1; mdr_at = 0; wr_at = 0; mdr_n = 0; wr_n = 0; lsz_bad = 1'b0;
            end else if (m_busy) begin
               cyc++;
            end
            prev_busy = m_busy;
            if (m_busy && (exp_q.size() > 0) && !exp_q[0].err && (m_lsz !== exp_q[0].lsz))
               lsz_bad = 1'b1;
            if (m_mdr) begin
               mdr_at = cyc;
               mdr_n++;
            end
            if (m_wr) begin
               wr_at = cyc;
               wr_n++;
               chk("wr_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  chk("wr_addr", m_maddr, exp_q[0].waddr);
                  chk("wr_data", m_wdata, exp_q[0].wdata);
               end
            end
            if (m_err) chk("err_with_done", m_done, 1);
            if (m_done) begin
               chk("done_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("addr_err", m_err, e.err);
                  chk("latency", cyc, e.lat);
                  chk("mdr_cycle", mdr_at, e.mdr);
                  chk("mdr_count", mdr_n, (e.mdr != 0) ? 1 : 0);
                  chk("wr_cycle", wr_at, e.wr);
                  chk("wr_count", wr_n, (e.wr != 0) ? 1 : 0);
                  chk("load_data", m_ld, e.ld);
                  chk("lsz_busy", lsz_bad, 0);
               end
               done_cnt++;
               after_done = 1'b1;
            end
         end
      end
   end

   // Issue one request to the selected instance; caller is just after a posedge in IDLE.
   task automatic issue(input logic sel, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] rdata, input exp_t e,
                        input bit hold);
      exp_q.push_back(e);
      tb_sel   = sel;
      tb_op    = op;
      tb_addr  = addr;
      tb_sd    = sd;
      tb_rdata = rdata;
      tb_req   = 1'b1;
      @(posedge clk);
      #1;
      chk("busy_on_accept", m_busy, 1);
      if (!hold) tb_req = 1'b0;
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; (i < 30) && (done_cnt < target); i++) @(posedge clk);
      chk("done_reached", done_cnt >= target, 1);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, m_busy, 0);
      chk({tag, "_done"}, m_done, 0);
      chk({tag, "_err"}, m_err, 0);
      chk({tag, "_wr"}, m_wr, 0);
      chk({tag, "_mdr"}, m_mdr, 0);
      chk({tag, "_maddr"}, m_maddr, 0);
      chk({tag, "_wdata"}, m_wdata, 0);
      chk({tag, "_ld"}, m_ld, 0);
      chk({tag, "_lsz"}, m_lsz, 2);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin : stim
      reset = 1'b0; tb_sel = 1'b0; tb_req = 1'b0; tb_op = 3'd0;
      tb_addr = 32'd0; tb_sd = 32'd0; tb_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      reset = 1'b1;
      @(posedge clk);
      #1;

      // LB at 0x103, MEM_LAT=1
      issue(1'b0, 3'b010, 32'h103, 32'h0, 32'hAABBCCDD,
            mk(1'b0, 3, 2, 0, 32'h0, 32'h0, 32'h000000DD, 2'b00), 1'b0);
      nd++; wait_done(nd);
      // SH at 0x200, MEM_LAT=3
      issue(1'b1, 3'b101, 32'h200, 32'h12345678, 32'hCAFEBABE,
            mk(1'b0, 6, 0, 5, 32'h200, 32'hCAFE5678, 32'h0, 2'b01), 1'b0);
      nd++; wait_done(nd);
      // LW misaligned
      issue(1'b0, 3'b000, 32'h102, 32'h0, 32'h0,
            mk(1'b1, 1, 0, 0, 32'h0, 32'h0, 32'h000000DD, 2'b10), 1'b0);
      nd++; wait_done(nd);
      // invalid op 011
      issue(1'b0, 3'b011, 32'h100, 32'h0, 32'h0,
            mk(1'b1, 1, 0, 0, 32'h0, 32'h0, 32'h000000DD, 2'b10), 1'b0);
      nd++; wait_done(nd);
      // LH at 0x102
      issue(1'b0, 3'b001, 32'h102, 32'h0, 32'h11223344,
            mk(1'b0, 3, 2, 0, 32'h0, 32'h0, 32'h00003344, 2'b01), 1'b0);
      nd++; wait_done(nd);
      // SB at 0x105
      issue(1'b0, 3'b110, 32'h105, 32'h000000EE, 32'h99887766,
            mk(1'b0, 4, 0, 3, 32'h105, 32'h998877EE, 32'h00003344, 2'b00), 1'b0);
      nd++; wait_done(nd);
      // SH misaligned
      issue(1'b0, 3'b101, 32'h101, 32'h0, 32'h0,
            mk(1'b1, 1, 0, 0, 32'h0, 32'h0, 32'h00003344, 2'b10), 1'b0);
      nd++; wait_done(nd);
      // LW at 0x300, MEM_LAT=3
      issue(1'b1, 3'b000, 32'h300, 32'h0, 32'hDEADBEEF,
            mk(1'b0, 5, 4, 0, 32'h0, 32'h0, 32'hDEADBEEF, 2'b10), 1'b0);
      nd++; wait_done(nd);

      // req held through an SW then an LW
      issue(1'b1, 3'b100, 32'h400, 32'h01020304, 32'h0,
            mk(1'b0, 6, 0, 5, 32'h400, 32'h01020304, 32'hDEADBEEF, 2'b10), 1'b1);
      exp_q.push_back(mk(1'b0, 5, 4, 0, 32'h0, 32'h0, 32'h55667788, 2'b10));
      tb_op = 3'b000; tb_addr = 32'h404; tb_rdata = 32'h55667788;
      nd++; wait_done(nd);
      chk("held_idle_busy", m_busy, 0);
      @(posedge clk);
      #1;
      chk("held_accept_busy", m_busy, 1);
      tb_req = 1'b0;
      nd++; wait_done(nd);

      // reset during RD_WAIT of an SB
      tb_sel = 1'b1; tb_op = 3'b110; tb_addr = 32'h501; tb_sd = 32'h000000AB;
      tb_rdata = 32'h11111111; tb_req = 1'b1;
      @(posedge clk);
      #1;
      tb_req = 1'b0;
      chk("abort_busy", m_busy, 1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk_reset_vals("abort");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt, nd);
      chk_reset_vals("post_abort");

      // next request completes normally
      issue(1'b1, 3'b010, 32'h502, 32'h0, 32'h00000042,
            mk(1'b0, 5, 4, 0, 32'h0, 32'h0, 32'h00000042, 2'b00), 1'b0);
      nd++; wait_done(nd);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
